// File: rtl/pwr_switch_ack_emu.sv
// ---------------------------------------------------------------------------
// pwr_switch_ack_emu
// Emulates the power-switch cells of several power domains. Each channel
// answers its switch request with an acknowledge that follows after a
// configurable power-on or power-off latency. A request that reverses while
// the switch is still ramping is aborted. An optional inrush limit restricts
// how many channels may ramp on at the same time.
//
// Ports
//   clk_i      : clock
//   rst_i      : synchronous reset, active high
//   switch_ni  : per-domain request, 0 = power on, 1 = power off
//   ack_no     : per-domain acknowledge, 0 = powered, 1 = off (registered)
//   ramping_o  : channel is ramping on or off (registered)
//   waiting_o  : channel is held back by the inrush limit (registered)
// ---------------------------------------------------------------------------
module pwr_switch_ack_emu #(
  parameter int   N_DOMAINS   = 4,
  parameter int   ON_LATENCY  = 15,
  parameter int   OFF_LATENCY = 15,
  parameter int   MAX_ON_RAMP = 0,
  parameter logic RST_ACK_N   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_DOMAINS-1:0] switch_ni,
  output logic [N_DOMAINS-1:0] ack_no,
  output logic [N_DOMAINS-1:0] ramping_o,
  output logic [N_DOMAINS-1:0] waiting_o
);

  typedef enum logic [2:0] {
    ST_ON       = 3'd0,
    ST_OFF      = 3'd1,
    ST_WAIT_ON  = 3'd2,
    ST_RAMP_ON  = 3'd3,
    ST_RAMP_OFF = 3'd4
  } state_e;

  localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Slot counters only ever count distinct channels, so N_DOMAINS bounds them.
  localparam int NW    = $clog2(N_DOMAINS + 1);
  localparam int MAX_C = (MAX_ON_RAMP > N_DOMAINS) ? N_DOMAINS : MAX_ON_RAMP;
  localparam logic [NW-1:0] MAX_SLOTS = NW'(MAX_C);
  localparam logic [NW-1:0] NW_ONE    = NW'(1);

  localparam state_e RST_STATE = (RST_ACK_N == 1'b1) ? ST_OFF : ST_ON;

  state_e                 state_r [N_DOMAINS];
  state_e                 state_s [N_DOMAINS];
  logic [CNT_W-1:0]       cnt_r   [N_DOMAINS];
  logic [CNT_W-1:0]       cnt_s   [N_DOMAINS];
  logic [N_DOMAINS-1:0]   admit_s;
  logic [NW-1:0]          ramp_on_cnt_s;
  logic [NW-1:0]          grant_cnt_s;
  logic [N_DOMAINS-1:0]   ack_r;
  logic [N_DOMAINS-1:0]   ramping_r;
  logic [N_DOMAINS-1:0]   waiting_r;

  // Inrush admission: free slots come from the registered RAMP_ON count, so a
  // channel finishing its ramp this cycle releases its slot one cycle later.
  always_comb begin
    ramp_on_cnt_s = '0;
    grant_cnt_s   = '0;
    admit_s       = '0;
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (state_r[i] == ST_RAMP_ON) begin
        ramp_on_cnt_s = ramp_on_cnt_s + NW_ONE;
      end else begin
        ramp_on_cnt_s = ramp_on_cnt_s;
      end
    end
    for (int i = 0; i < N_DOMAINS; i++) begin
      if (((state_r[i] == ST_OFF) || (state_r[i] == ST_WAIT_ON)) && !switch_ni[i]) begin
        if (MAX_ON_RAMP == 0) begin
          admit_s[i] = 1'b1;
        end else if ((ramp_on_cnt_s + grant_cnt_s) < MAX_SLOTS) begin
          admit_s[i]  = 1'b1;
          grant_cnt_s = grant_cnt_s + NW_ONE;
        end else begin
          admit_s[i] = 1'b0;
        end
      end else begin
        admit_s[i] = 1'b0;
      end
    end
  end

  // Per-channel next state and counter. A reversal takes priority over
  // completion so an aborted ramp never produces an acknowledge edge.
  always_comb begin
    for (int i = 0; i < N_DOMAINS; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_ON: begin
          if (switch_ni[i]) begin
            state_s[i] = ST_RAMP_OFF;
            cnt_s[i]   = OFF_LOAD;
          end else begin
            state_s[i] = ST_ON;
          end
        end
        ST_OFF: begin
          if (admit_s[i]) begin
            state_s[i] = ST_RAMP_ON;
            cnt_s[i]   = ON_LOAD;
          end else if (!switch_ni[i]) begin
            state_s[i] = ST_WAIT_ON;
          end else begin
            state_s[i] = ST_OFF;
          end
        end
        ST_WAIT_ON: begin
          if (switch_ni[i]) begin
            state_s[i] = ST_OFF;
          end else if (admit_s[i]) begin
            state_s[i] = ST_RAMP_ON;
            cnt_s[i]   = ON_LOAD;
          end else begin
            state_s[i] = ST_WAIT_ON;
          end
        end
        ST_RAMP_ON: begin
          if (switch_ni[i]) begin
            state_s[i] = ST_OFF;
            cnt_s[i]   = '0;
          end else if (cnt_r[i] == '0) begin
            state_s[i] = ST_ON;
          end else begin
            cnt_s[i] = cnt_r[i] - CNT_ONE;
          end
        end
        ST_RAMP_OFF: begin
          if (!switch_ni[i]) begin
            state_s[i] = ST_ON;
            cnt_s[i]   = '0;
          end else if (cnt_r[i] == '0) begin
            state_s[i] = ST_OFF;
          end else begin
            cnt_s[i] = cnt_r[i] - CNT_ONE;
          end
        end
        default: begin
          state_s[i] = RST_STATE;
          cnt_s[i]   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; ack only moves on stable-state entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        state_r[i]   <= RST_STATE;
        cnt_r[i]     <= '0;
        ack_r[i]     <= RST_ACK_N;
        ramping_r[i] <= 1'b0;
        waiting_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_DOMAINS; i++) begin
        state_r[i]   <= state_s[i];
        cnt_r[i]     <= cnt_s[i];
        if (state_s[i] == ST_ON) begin
          ack_r[i] <= 1'b0;
        end else if (state_s[i] == ST_OFF) begin
          ack_r[i] <= 1'b1;
        end else begin
          ack_r[i] <= ack_r[i];
        end
        ramping_r[i] <= (state_s[i] == ST_RAMP_ON) || (state_s[i] == ST_RAMP_OFF);
        waiting_r[i] <= (state_s[i] == ST_WAIT_ON);
      end
    end
  end

  assign ack_no    = ack_r;
  assign ramping_o = ramping_r;
  assign waiting_o = waiting_r;

endmodule

// File: tb/tb_pwr_switch_ack_emu.sv
// ---------------------------------------------------------------------------
// tb_pwr_switch_ack_emu
// Three instances with different parameter sets:
//   a : defaults (N=4, ON=OFF=15, unlimited, reset powered on)
//   b : N=4, ON=4, OFF=7, one ramp-on slot, reset powered off
//   c : N=3, ON=1, OFF=3, two ramp-on slots, reset powered on (random only)
// A reference model tracks each channel as "acknowledge value, pending flip
// deadline, waiting flag" and is compared against every output after every
// edge, alongside directed timing checks.
// ---------------------------------------------------------------------------
module tb_pwr_switch_ack_emu;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw [3];

  logic [3:0] ack_a, ramp_a, wait_a;
  logic [3:0] ack_b, ramp_b, wait_b;
  logic [2:0] ack_c, ramp_c, wait_c;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int on_l  [3] = '{15, 4, 1};
  int off_l [3] = '{15, 7, 3};
  int maxr  [3] = '{0, 1, 2};
  bit rst_v [3] = '{1'b0, 1'b1, 1'b0};
  int nd    [3] = '{4, 4, 3};
  bit ack_m  [3][4];
  bit ramp_m [3][4];
  bit wait_m [3][4];
  int flip_at[3][4];

  always #5 clk = ~clk;

  pwr_switch_ack_emu dut_a (
    .clk_i(clk), .rst_i(rst), .switch_ni(sw[0]),
    .ack_no(ack_a), .ramping_o(ramp_a), .waiting_o(wait_a)
  );

  pwr_switch_ack_emu #(
    .N_DOMAINS(4), .ON_LATENCY(4), .OFF_LATENCY(7), .MAX_ON_RAMP(1), .RST_ACK_N(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .switch_ni(sw[1]),
    .ack_no(ack_b), .ramping_o(ramp_b), .waiting_o(wait_b)
  );

  pwr_switch_ack_emu #(
    .N_DOMAINS(3), .ON_LATENCY(1), .OFF_LATENCY(3), .MAX_ON_RAMP(2), .RST_ACK_N(1'b0)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .switch_ni(sw[2][2:0]),
    .ack_no(ack_c), .ramping_o(ramp_c), .waiting_o(wait_c)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4; i++) begin
        ack_m[d][i]   = (i < nd[d]) ? rst_v[d] : 1'b0;
        ramp_m[d][i]  = 1'b0;
        wait_m[d][i]  = 1'b0;
        flip_at[d][i] = -1;
      end
  endtask

  // One clock edge of the switch rules for instance d, time t.
  task automatic model_step(input int d, input logic [3:0] s, input int t);
    int nr = 0;
    int g  = 0;
    bit cand [4];
    for (int i = 0; i < nd[d]; i++)
      if (ramp_m[d][i] && ack_m[d][i]) nr++;
    for (int i = 0; i < nd[d]; i++) begin
      cand[i] = 1'b0;
      if (ramp_m[d][i]) begin
        if (s[i] == ack_m[d][i]) ramp_m[d][i] = 1'b0;           // reversal
        else if (t == flip_at[d][i]) begin
          ack_m[d][i]  = ~ack_m[d][i];
          ramp_m[d][i] = 1'b0;
        end
      end else if (wait_m[d][i]) begin
        if (s[i]) wait_m[d][i] = 1'b0;
        else cand[i] = 1'b1;
      end else if (!ack_m[d][i]) begin
        if (s[i]) begin
          ramp_m[d][i]  = 1'b1;
          flip_at[d][i] = t + off_l[d];
        end
      end else begin
        if (!s[i]) cand[i] = 1'b1;
      end
    end
    for (int i = 0; i < nd[d]; i++)
      if (cand[i]) begin
        if (maxr[d] == 0 || g < maxr[d] - nr) begin
          ramp_m[d][i]  = 1'b1;
          wait_m[d][i]  = 1'b0;
          flip_at[d][i] = t + on_l[d];
          g++;
        end else begin
          wait_m[d][i] = 1'b1;
        end
      end
  endtask

  task automatic compare_all();
    logic [3:0] ea, er, ew, oa, orr, ow;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        ea[i] = ack_m[d][i];
        er[i] = ramp_m[d][i];
        ew[i] = wait_m[d][i];
      end
      case (d)
        0: begin oa = ack_a; orr = ramp_a; ow = wait_a; end
        1: begin oa = ack_b; orr = ramp_b; ow = wait_b; end
        default: begin oa = {1'b0, ack_c}; orr = {1'b0, ramp_c}; ow = {1'b0, wait_c}; end
      endcase
      chk($sformatf("mdl_ack_%0d", d), oa, ea);
      chk($sformatf("mdl_ramp_%0d", d), orr, er);
      chk($sformatf("mdl_wait_%0d", d), ow, ew);
    end
  endtask

  // Advance one edge; instance c always gets random request flips.
  task automatic tick();
    for (int b = 0; b < 3; b++)
      if ($urandom_range(7) == 0) sw[2][b] = ~sw[2][b];
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else for (int d = 0; d < 3; d++) model_step(d, sw[d], cyc);
    #1;
    compare_all();
  endtask

  initial begin
    int e0;
    int fall [4];
    logic [3:0] prev;

    rst   = 1'b1;
    sw[0] = 4'b0000;
    sw[1] = 4'b1111;
    sw[2] = 4'b0000;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ack_a", ack_a, 4'b0000);
    chk("rst_ramp_a", ramp_a, 4'b0000);
    chk("rst_ack_b", ack_b, 4'b1111);
    chk("rst_wait_b", wait_b, 4'b0000);

    // power-off latency on the default instance
    sw[0][2] = 1'b1;
    tick();
    chk("off_ramp_start", {3'b000, ramp_a[2]}, 4'b0001);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("off_ack_hold", {3'b000, ack_a[2]}, 4'b0000);
      chk("off_ramp_hold", {3'b000, ramp_a[2]}, 4'b0001);
    end
    tick();
    chk("off_ack_e15", {3'b000, ack_a[2]}, 4'b0001);
    chk("off_ramp_end", {3'b000, ramp_a[2]}, 4'b0000);

    // reversal: raise then drop 5 cycles later
    sw[0][0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rev_ack_hold", {3'b000, ack_a[0]}, 4'b0000);
    end
    sw[0][0] = 1'b0;
    tick();
    chk("rev_ramp_clear", {3'b000, ramp_a[0]}, 4'b0000);
    chk("rev_ack_stay", {3'b000, ack_a[0]}, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("rev_ack_quiet", {3'b000, ack_a[0]}, 4'b0000);
    end

    // inrush limit: all on at once, then channel 3 aborts from WAIT_ON
    sw[1] = 4'b0000;
    tick();
    e0 = cyc;
    chk("inrush_wait", wait_b, 4'b1110);
    chk("inrush_ramp", ramp_b, 4'b0001);
    sw[1][3] = 1'b1;
    tick();
    chk("abort_wait", wait_b, 4'b0110);
    chk("abort_ack", ack_b, 4'b1111);
    for (int i = 0; i < 4; i++) fall[i] = -1;
    for (int k = 0; k < 25; k++) begin
      prev = ack_b;
      tick();
      for (int i = 0; i < 4; i++)
        if (prev[i] && !ack_b[i] && fall[i] < 0) fall[i] = cyc;
    end
    chk("inrush_first", 4'(fall[0] - e0), 4'd4);
    chk("inrush_gap01", 4'(fall[1] - fall[0]), 4'd5);
    chk("inrush_gap12", 4'(fall[2] - fall[1]), 4'd5);
    chk("inrush_final", ack_b, 4'b1000);
    chk("abort_never", {3'b000, ramp_b[3] | wait_b[3]}, 4'b0000);

    // asymmetric latencies on channel 0 of b
    sw[1][0] = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("asym_off_hold", {3'b000, ack_b[0]}, 4'b0000);
    end
    tick();
    chk("asym_off_7", {3'b000, ack_b[0]}, 4'b0001);
    sw[1][0] = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("asym_on_hold", {3'b000, ack_b[0]}, 4'b0001);
    end
    tick();
    chk("asym_on_4", {3'b000, ack_b[0]}, 4'b0000);

    // reset in the middle of a power-off ramp (counter at 6)
    sw[1][1] = 1'b1;
    tick();
    rst   = 1'b1;
    sw[0] = 4'b0000;
    sw[1] = 4'b1111;
    tick();
    rst = 1'b0;
    chk("mrst_ack_b", ack_b, 4'b1111);
    chk("mrst_ramp_b", ramp_b, 4'b0000);
    chk("mrst_ack_a", ack_a, 4'b0000);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("mrst_no_late", ack_b, 4'b1111);
    end

    // randomized phase against the model
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < 4; b++)
          if ($urandom_range(9) == 0) sw[d][b] = ~sw[d][b];
      rst = ($urandom_range(399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
